// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests and MEM exception info in, stall/flush/redirect out.
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: stall vector, exception flush/redirect, stall-cycle
// counters and an EX-stall watchdog for bring-up.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [15:0] WDOG_LIMIT = 16'd1023
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus,
    input  logic [1:0]    cnt_sel,
    input  logic          cnt_clr,
    output logic [31:0]   cnt_value,
    output logic [31:0]   exc_count,
    output logic          wdog_trip
);
    typedef enum logic {RUN, REDIRECT} state_t;

    state_t            state, state_nxt;
    logic [5:0]        req_vec;
    logic [3:0]        win;          // one-hot winner: 0 IF, 1 ID, 2 EX, 3 MEM
    logic              accept;
    logic              flush_c;
    logic [31:0]       target;
    logic [31:0]       redir_pc;
    logic [3:0][31:0]  stall_cnt;
    logic [15:0]       run_cnt, run_nxt;

    always_comb begin
        req_vec = 6'b000000;
        win     = 4'b0000;
        if (bus.stallreq_from_mem) begin
            req_vec = 6'b011111; win = 4'b1000;
        end else if (bus.stallreq_from_ex) begin
            req_vec = 6'b001111; win = 4'b0100;
        end else if (bus.stallreq_from_id) begin
            req_vec = 6'b000111; win = 4'b0010;
        end else if (bus.stallreq_from_if) begin
            req_vec = 6'b000011; win = 4'b0001;
        end
    end

    // A MEM stall defers the flush; the latches keep excepttype_i stable meanwhile.
    assign accept = (state == RUN) && (bus.excepttype_i != 32'd0) && !bus.stallreq_from_mem;
    assign target = (bus.excepttype_i == 32'h0000_000e) ? bus.cp0_epc_i : EXC_VECTOR;

    always_comb begin
        state_nxt = state;
        flush_c   = 1'b0;
        case (state)
            RUN: if (accept) begin
                state_nxt = REDIRECT;
                flush_c   = 1'b1;
            end
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        bus.stall  = 6'b000000;
        bus.flush  = 1'b0;
        bus.new_pc = 32'd0;
        if (rst) begin
            bus.stall  = flush_c ? 6'b000000 : req_vec;
            bus.flush  = flush_c;
            bus.new_pc = (state == REDIRECT) ? redir_pc : target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            redir_pc <= 32'd0;
        end else begin
            state <= state_nxt;
            if (flush_c) redir_pc <= target;
        end
    end

    always_comb begin
        run_nxt = 16'd0;
        if (bus.stallreq_from_ex)
            run_nxt = (run_cnt >= WDOG_LIMIT) ? WDOG_LIMIT : run_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            exc_count <= 32'd0;
            run_cnt   <= 16'd0;
            wdog_trip <= 1'b0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            exc_count <= 32'd0;
            run_cnt   <= 16'd0;
            wdog_trip <= 1'b0;
        end else begin
            // A flush overrides the stall vector, so no source wins that cycle.
            for (int i = 0; i < 4; i++)
                if (win[i] && !flush_c) stall_cnt[i] <= stall_cnt[i] + 32'd1;
            if (flush_c) exc_count <= exc_count + 32'd1;
            run_cnt <= run_nxt;
            if (bus.stallreq_from_ex && run_nxt == WDOG_LIMIT) wdog_trip <= 1'b1;
        end
    end

    assign cnt_value = stall_cnt[cnt_sel];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;
    localparam logic [15:0] LIM = 16'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cnt_sel;
    logic        cnt_clr;
    logic [31:0] cnt_value, exc_count;
    logic        wdog_trip;

    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.WDOG_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_value(cnt_value),
        .exc_count(exc_count), .wdog_trip(wdog_trip)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_redir;
    logic [31:0] m_lpc;
    logic [31:0] m_cnt [4];
    logic [31:0] m_exc;
    int          m_run;
    bit          m_trip;

    // comb outputs observed in the last cycle() call
    logic [5:0]  obs_stall;
    logic        obs_flush;
    logic [31:0] obs_pc;

    task automatic model_reset();
        m_redir = 0; m_lpc = 0; m_exc = 0; m_run = 0; m_trip = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic set_in(bit r_if, bit r_id, bit r_ex, bit r_mem, logic [31:0] exc, logic [31:0] epc, bit clr);
        bus.stallreq_from_if  = r_if;
        bus.stallreq_from_id  = r_id;
        bus.stallreq_from_ex  = r_ex;
        bus.stallreq_from_mem = r_mem;
        bus.excepttype_i      = exc;
        bus.cp0_epc_i         = epc;
        cnt_clr               = clr;
    endtask

    task automatic check_regs(string tag);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            checks++;
            if (cnt_value !== m_cnt[s]) begin
                errors++;
                $display("FAIL %s cnt_value[%0d] got=%0d exp=%0d", tag, s, cnt_value, m_cnt[s]);
            end
        end
        checks++;
        if (exc_count !== m_exc) begin
            errors++;
            $display("FAIL %s exc_count got=%0d exp=%0d", tag, exc_count, m_exc);
        end
        checks++;
        if (wdog_trip !== m_trip) begin
            errors++;
            $display("FAIL %s wdog_trip got=%0b exp=%0b", tag, wdog_trip, m_trip);
        end
    endtask

    // One clock: check comb outputs against the model, clock, advance model, check registers.
    task automatic cycle(string tag);
        int          w;
        bit          acc;
        logic [5:0]  e_stall;
        logic [31:0] e_pc;
        w = bus.stallreq_from_mem ? 3 : bus.stallreq_from_ex ? 2 :
            bus.stallreq_from_id  ? 1 : bus.stallreq_from_if ? 0 : -1;
        acc = (bus.excepttype_i != 0) && !bus.stallreq_from_mem && !m_redir;
        e_stall = (acc || w < 0) ? 6'd0 : 6'((1 << (w + 2)) - 1);
        e_pc = m_redir ? m_lpc : (bus.excepttype_i == 32'he) ? bus.cp0_epc_i : 32'h20;
        #1;
        obs_stall = bus.stall; obs_flush = bus.flush; obs_pc = bus.new_pc;
        checks++;
        if (bus.stall !== e_stall) begin
            errors++;
            $display("FAIL %s stall got=%b exp=%b", tag, bus.stall, e_stall);
        end
        checks++;
        if (bus.flush !== acc) begin
            errors++;
            $display("FAIL %s flush got=%b exp=%b", tag, bus.flush, acc);
        end
        if (acc || m_redir) begin
            checks++;
            if (bus.new_pc !== e_pc) begin
                errors++;
                $display("FAIL %s new_pc got=%h exp=%h", tag, bus.new_pc, e_pc);
            end
        end
        @(posedge clk);
        if (cnt_clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_exc = 0; m_run = 0; m_trip = 0;
        end else begin
            if (!acc && w >= 0) m_cnt[w] = m_cnt[w] + 1;
            if (acc) m_exc = m_exc + 1;
            m_run = bus.stallreq_from_ex ? ((m_run < int'(LIM)) ? m_run + 1 : int'(LIM)) : 0;
            if (m_run == int'(LIM)) m_trip = 1;
        end
        if (acc) m_lpc = e_pc;
        m_redir = acc;
        #1;
        check_regs(tag);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1, 1, 1, 1, 32'h8, 32'h1234, 0);
        model_reset();
        #3;
        checks++;
        if (bus.stall !== 6'd0 || bus.flush !== 1'b0 || bus.new_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b flush=%b pc=%h exp 0/0/0", bus.stall, bus.flush, bus.new_pc);
        end
        check_regs("reset");
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_priority();
        set_in(0, 0, 0, 0, 0, 0, 1);
        cycle("prio_clr");
        set_in(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("prio");
        checks++;
        if (obs_stall !== 6'b011111) begin
            errors++;
            $display("FAIL prio_stall got=%b exp=011111", obs_stall);
        end
        cnt_sel = 2'd3; #1;
        checks++;
        if (cnt_value !== 32'd3) begin errors++; $display("FAIL prio_mem_cnt got=%0d exp=3", cnt_value); end
        cnt_sel = 2'd1; #1;
        checks++;
        if (cnt_value !== 32'd0) begin errors++; $display("FAIL prio_id_cnt got=%0d exp=0", cnt_value); end
    endtask

    task automatic test_syscall();
        set_in(0, 0, 0, 0, 0, 0, 1);
        cycle("sys_clr");
        set_in(0, 0, 1, 0, 32'h8, 32'hdead_beef, 0);
        cycle("sys1");
        checks++;
        if (obs_flush !== 1'b1 || obs_stall !== 6'd0 || obs_pc !== 32'h20) begin
            errors++;
            $display("FAIL syscall_flush got flush=%b stall=%b pc=%h exp 1/000000/00000020", obs_flush, obs_stall, obs_pc);
        end
        cycle("sys2");
        checks++;
        if (obs_flush !== 1'b0 || obs_stall !== 6'b001111) begin
            errors++;
            $display("FAIL syscall_redirect got flush=%b stall=%b exp 0/001111", obs_flush, obs_stall);
        end
        checks++;
        if (exc_count !== 32'd1) begin errors++; $display("FAIL syscall_exc_count got=%0d exp=1", exc_count); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle("sys_idle");
    endtask

    task automatic test_eret();
        set_in(0, 0, 0, 0, 32'he, 32'hbfc0_0100, 0);
        cycle("eret");
        checks++;
        if (obs_flush !== 1'b1 || obs_pc !== 32'hbfc0_0100) begin
            errors++;
            $display("FAIL eret got flush=%b pc=%h exp 1/bfc00100", obs_flush, obs_pc);
        end
        cycle("eret_redir");
        checks++;
        if (obs_pc !== 32'hbfc0_0100) begin errors++; $display("FAIL eret_hold_pc got=%h exp=bfc00100", obs_pc); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle("eret_idle");
    endtask

    task automatic test_deferred_flush();
        set_in(0, 0, 0, 1, 32'h4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("defer_stall");
            checks++;
            if (obs_flush !== 1'b0 || obs_stall !== 6'b011111) begin
                errors++;
                $display("FAIL defer_cycle%0d got flush=%b stall=%b exp 0/011111", i, obs_flush, obs_stall);
            end
        end
        bus.stallreq_from_mem = 1'b0;
        cycle("defer_take");
        checks++;
        if (obs_flush !== 1'b1) begin errors++; $display("FAIL defer_take flush got=%b exp=1", obs_flush); end
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle("defer_idle");
    endtask

    task automatic test_back_to_back();
        set_in(0, 0, 0, 0, 32'h8, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("b2b");
            checks++;
            if (obs_flush !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_cycle%0d flush got=%b exp=%b", i, obs_flush, ((i % 2) == 0));
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle("b2b_idle");
    endtask

    task automatic test_watchdog();
        set_in(0, 0, 0, 0, 0, 0, 1);
        cycle("wd_clr");
        set_in(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cycle("wd_run1");
            checks++;
            if (wdog_trip !== 1'b0) begin errors++; $display("FAIL wd_run1_%0d trip got=%b exp=0", i, wdog_trip); end
        end
        bus.stallreq_from_ex = 1'b0;
        cycle("wd_gap");
        bus.stallreq_from_ex = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle("wd_run2");
            checks++;
            if (wdog_trip !== (i == 7)) begin
                errors++;
                $display("FAIL wd_run2_%0d trip got=%b exp=%b", i, wdog_trip, (i == 7));
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 1);
        cycle("wd_clear");
        checks++;
        if (wdog_trip !== 1'b0) begin errors++; $display("FAIL wd_clear trip got=%b exp=0", wdog_trip); end
        cnt_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("ar_pre");
        set_in(0, 0, 0, 1, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.stall !== 6'd0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_stall got stall=%b flush=%b exp 0/0", bus.stall, bus.flush);
        end
        check_regs("async_reset_stall");
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 1, 0, 32'h8, 0, 0);
        #1;
        checks++;
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL async_pre_flush got=%b exp=1", bus.flush); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.flush !== 1'b0 || bus.stall !== 6'd0 || bus.new_pc !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_flush got flush=%b stall=%b pc=%h exp 0/0/0", bus.flush, bus.stall, bus.new_pc);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_random();
        logic [31:0] exc;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(9))
                0:       exc = 32'h8;
                1:       exc = 32'he;
                2:       exc = $urandom;
                default: exc = 32'h0;
            endcase
            set_in($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
                   $urandom_range(4) == 0, exc, $urandom, $urandom_range(40) == 0);
            cycle("random");
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cnt_sel = 2'd0;
        test_reset();
        test_priority();
        test_syscall();
        test_eret();
        test_deferred_flush();
        test_back_to_back();
        test_watchdog();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
